// File: rtl/color_step_if.sv
// Handshake bundle between the VGA timing/control side and the colour step scheduler.
// The master drives frame timing and user controls; the slave returns the colour index state.
interface color_step_if #(
    parameter int DIV_W = 8
) ();
    logic             vsync_start;
    logic             run;
    logic [DIV_W-1:0] frame_div;
    logic             man_step;
    logic             clear;
    logic             step_pulse;
    logic [2:0]       color_idx;
    logic             dir_down;
    logic             running;

    modport master (
        output vsync_start, run, frame_div, man_step, clear,
        input  step_pulse, color_idx, dir_down, running
    );

    modport slave (
        input  vsync_start, run, frame_div, man_step, clear,
        output step_pulse, color_idx, dir_down, running
    );
endinterface

// File: rtl/color_step_scheduler.sv
// Frame-synchronous owner of the 3-bit ping-pong colour index (0..7..0).
// Automatic and manual step requests are merged and applied only at vertical-blank start.
module color_step_scheduler #(
    parameter int DIV_W = 8
) (
    input  logic         clk,
    input  logic         reset,
    color_step_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] fcnt_q, fcnt_d;
    logic             man_step_q;
    logic             man_pend_q, man_pend_d;
    logic [2:0]       idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             pulse_q, pulse_d;

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] div_m1;
    logic             man_rise;
    logic             pend_now;
    logic             auto_due;
    logic             do_step;

    assign div_eff  = (bus.frame_div == '0) ? DIV_W'(1) : bus.frame_div;
    assign div_m1   = div_eff - DIV_W'(1);
    assign man_rise = bus.man_step & ~man_step_q;
    // A press landing on the vsync cycle itself is served by that vsync.
    assign pend_now = man_pend_q | man_rise;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        auto_due = 1'b0;
        case (state_q)
            IDLE: begin
                fcnt_d = '0;
                if (bus.run) state_d = ARM;
            end
            ARM: begin
                if (!bus.run) begin
                    state_d = IDLE;
                end else if (bus.vsync_start) begin
                    state_d = RUN;
                    fcnt_d  = '0;
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end else if (bus.vsync_start) begin
                    // >= lets a shrunk frame_div wrap immediately instead of overshooting.
                    if (fcnt_q >= div_m1) begin
                        auto_due = 1'b1;
                        fcnt_d   = '0;
                    end else begin
                        fcnt_d = fcnt_q + DIV_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        do_step    = bus.vsync_start & (auto_due | pend_now);
        idx_d      = idx_q;
        dir_d      = dir_q;
        pulse_d    = do_step;
        man_pend_d = do_step ? 1'b0 : pend_now;

        if (do_step) begin
            if (!dir_q) begin
                idx_d = idx_q + 3'd1;
                dir_d = (idx_q == 3'd6);
            end else begin
                idx_d = idx_q - 3'd1;
                dir_d = (idx_q != 3'd1);
            end
        end

        if (bus.clear) begin
            idx_d      = '0;
            dir_d      = 1'b0;
            fcnt_d     = '0;
            man_pend_d = 1'b0;
            pulse_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            fcnt_q     <= '0;
            man_step_q <= 1'b0;
            man_pend_q <= 1'b0;
            idx_q      <= '0;
            dir_q      <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            man_step_q <= bus.man_step;
            man_pend_q <= man_pend_d;
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            pulse_q    <= pulse_d;
        end
    end

    assign bus.step_pulse = pulse_q;
    assign bus.color_idx  = idx_q;
    assign bus.dir_down   = dir_q;
    assign bus.running    = (state_q == RUN);
endmodule

// File: tb/tb_color_step_scheduler.sv
// Directed and random stimulus for color_step_scheduler, checked cycle by cycle against a
// position-on-a-14-step-cycle reference model.
module tb_color_step_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    color_step_if #(.DIV_W(8)) bus ();

    color_step_scheduler #(.DIV_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 stopped, 1 waiting for first frame, 2 counting frames.
    int m_mode, m_frames, m_pos;
    bit m_pend, m_prev_man, m_pulse;

    function automatic int exp_idx();
        return (m_pos <= 7) ? m_pos : 14 - m_pos;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_frames = 0; m_pos = 0;
        m_pend = 0; m_prev_man = 0; m_pulse = 0;
    endtask

    task automatic model_eval();
        bit rise, pend, auto_step, step;
        int deff;
        deff = (bus.frame_div == 0) ? 1 : int'(bus.frame_div);
        rise = bus.man_step && !m_prev_man;
        m_prev_man = bus.man_step;
        pend = m_pend || rise;
        auto_step = 0;
        if (m_mode == 0) begin
            m_frames = 0;
            if (bus.run) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!bus.run) m_mode = 0;
            else if (bus.vsync_start) begin m_mode = 2; m_frames = 0; end
        end else begin
            if (!bus.run) begin m_mode = 0; m_frames = 0; end
            else if (bus.vsync_start) begin
                if (m_frames + 1 >= deff) begin auto_step = 1; m_frames = 0; end
                else m_frames++;
            end
        end
        step = bus.vsync_start && (auto_step || pend);
        if (bus.clear) begin
            m_pos = 0; m_frames = 0; m_pend = 0; m_pulse = 0;
        end else begin
            m_pulse = step;
            if (step) m_pos = (m_pos + 1) % 14;
            m_pend = step ? 1'b0 : pend;
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".step_pulse"}, int'(bus.step_pulse), int'(m_pulse));
        chk({where, ".color_idx"},  int'(bus.color_idx),  exp_idx());
        chk({where, ".dir_down"},   int'(bus.dir_down),   (m_pos >= 7) ? 1 : 0);
        chk({where, ".running"},    int'(bus.running),    (m_mode == 2) ? 1 : 0);
    endtask

    task automatic cycle(input string where);
        model_eval();
        @(posedge clk);
        #1;
        check_all(where);
        $display("%0t %s vs=%0b run=%0b div=%0d man=%0b clr=%0b -> pulse=%0b idx=%0d dir=%0b running=%0b",
                 $time, where, bus.vsync_start, bus.run, bus.frame_div, bus.man_step, bus.clear,
                 bus.step_pulse, bus.color_idx, bus.dir_down, bus.running);
    endtask

    task automatic frames(input string where, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.vsync_start = 1'b0;
            repeat (gap) cycle(where);
            bus.vsync_start = 1'b1;
            cycle(where);
            bus.vsync_start = 1'b0;
        end
    endtask

    task automatic do_reset(input string where);
        #2 reset = 1'b1;
        bus.man_step = 1'b0;
        model_reset();
        #1;
        check_all({where, ".in_reset"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.vsync_start = 0; bus.run = 0; bus.frame_div = 8'd1;
        bus.man_step = 0; bus.clear = 0;
        model_reset();
        @(negedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Auto stepping every 3 frames; the first vsync only arms.
        bus.run = 1; bus.frame_div = 8'd3;
        cycle("div3"); cycle("div3");
        frames("div3", 10, 2);
        chk("div3.final_idx", int'(bus.color_idx), 3);

        // frame_div=0 steps every frame: ping-pong past both ends.
        do_reset("div0");
        bus.run = 1; bus.frame_div = 8'd0;
        cycle("div0"); cycle("div0");
        frames("div0", 16, 1);
        chk("div0.final_idx", int'(bus.color_idx), 1);
        chk("div0.final_dir", int'(bus.dir_down), 0);

        // Two button rises between vsyncs collapse into one step.
        do_reset("man2");
        bus.run = 0;
        cycle("man2");
        bus.man_step = 1; cycle("man2");
        bus.man_step = 0; cycle("man2");
        bus.man_step = 1; cycle("man2");
        bus.man_step = 0; cycle("man2");
        frames("man2", 1, 1);
        chk("man2.after_first", int'(bus.color_idx), 1);
        frames("man2", 1, 1);
        chk("man2.after_second", int'(bus.color_idx), 1);

        // Manual rise on a due vsync merges with the auto step.
        do_reset("merge");
        bus.run = 1; bus.frame_div = 8'd2;
        cycle("merge");
        frames("merge", 2, 2);
        bus.vsync_start = 1; bus.man_step = 1;
        cycle("merge");
        bus.vsync_start = 0;
        chk("merge.idx", int'(bus.color_idx), 1);
        bus.man_step = 0;
        frames("merge", 4, 2);
        chk("merge.idx_later", int'(bus.color_idx), 3);

        // Shrinking frame_div mid-count wraps at the next vsync.
        do_reset("shrink");
        bus.run = 1; bus.frame_div = 8'd200;
        cycle("shrink");
        frames("shrink", 51, 1);
        bus.frame_div = 8'd2;
        frames("shrink", 5, 1);
        chk("shrink.idx", int'(bus.color_idx), 3);

        // Clear on a due vsync suppresses the step; reset drops a pending press.
        do_reset("clear");
        bus.run = 1; bus.frame_div = 8'd0;
        cycle("clear");
        frames("clear", 6, 1);
        bus.vsync_start = 1; bus.clear = 1;
        cycle("clear");
        bus.vsync_start = 0; bus.clear = 0;
        chk("clear.idx", int'(bus.color_idx), 0);
        chk("clear.pulse", int'(bus.step_pulse), 0);
        bus.run = 0;
        bus.man_step = 1; cycle("clear");
        bus.man_step = 0; cycle("clear");
        do_reset("rstpend");
        frames("rstpend", 2, 1);
        chk("rstpend.idx", int'(bus.color_idx), 0);

        // Random mix of all controls.
        for (int i = 0; i < 2500; i++) begin
            bus.vsync_start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 40) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 60) == 0) bus.frame_div = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 6) == 0) bus.man_step = ~bus.man_step;
            bus.clear = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 400) == 0) do_reset("rand");
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
